// File: rtl/cic_comb_decimator_if.sv
// rtl/cic_comb_decimator_if.sv - sample stream and control bundle for the CIC comb decimator
interface cic_comb_decimator_if #(
   parameter int N  = 16,
   parameter int RW = 8
);
   logic          clr;
   logic          in_valid;
   logic [N-1:0]  data_in;
   logic [RW-1:0] dec_ratio;
   logic [N-1:0]  data_out;
   logic          valid_out;

   modport master (
      output clr,
      output in_valid,
      output data_in,
      output dec_ratio,
      input  data_out,
      input  valid_out
   );

   modport slave (
      input  clr,
      input  in_valid,
      input  data_in,
      input  dec_ratio,
      output data_out,
      output valid_out
   );
endinterface

// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - CIC decimator back end: sample-rate reduction followed by a comb cascade
module cic_comb_decimator #(
   parameter int N      = 16,
   parameter int STAGES = 3,
   parameter int RW     = 8
) (
   input  logic                  clk,
   input  logic                  rstb,
   cic_comb_decimator_if.slave   bus
);
   logic [RW-1:0] cnt;
   logic [RW-1:0] reff_m1;
   logic          capture;

   // c[0] is the decimated sample; c[i], d[i-1], v[i] belong to comb stage i
   logic [N-1:0]  c [0:STAGES];
   logic [N-1:0]  d [0:STAGES-1];
   logic [STAGES:0] v;

   always_comb begin
      reff_m1 = '0;
      if (bus.dec_ratio >= RW'(2)) begin
         reff_m1 = bus.dec_ratio - 1'b1;
      end
      capture = bus.in_valid && (cnt >= reff_m1);
   end

   always_ff @(posedge clk) begin
      if (!rstb || bus.clr) begin
         cnt <= '0;
         v   <= '0;
         for (int i = 0; i <= STAGES; i++) begin
            c[i] <= '0;
         end
         for (int i = 0; i < STAGES; i++) begin
            d[i] <= '0;
         end
      end else begin
         v[0] <= 1'b0;
         if (capture) begin
            c[0] <= bus.data_in;
            v[0] <= 1'b1;
            cnt  <= '0;
         end else if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
         end
         // Differences wrap modulo 2^N; the integrator growth relies on it
         for (int i = 1; i <= STAGES; i++) begin
            if (v[i-1]) begin
               c[i]   <= c[i-1] - d[i-1];
               d[i-1] <= c[i-1];
               v[i]   <= 1'b1;
            end else begin
               v[i]   <= 1'b0;
            end
         end
      end
   end

   assign bus.data_out  = c[STAGES];
   assign bus.valid_out = v[STAGES];
endmodule
